io_clk_wkup_seq: RTL and testbench

//  - Multi-channel, sequenced clock-wakeup drain driver. Successor to the single-channel enb-gated drain.
//  - Per channel: drives drain_out to 1 for a programmable hold time, then releases it to Z.
//  - Channels are served one at a time, round-robin, so adjacent IO wakeup drains never drive together.
//  - Sits in the IO common block between the wakeup request logic and the clock-pad drain nets.

---
 rtl/io_clk_wkup_pkg.sv | 16 +
 rtl/io_clk_wkup_rr_arb.sv | 34 +++
 rtl/io_clk_wkup_seq.sv | 138 +++++++++++++
 tb/tb_io_clk_wkup_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_clk_wkup_pkg.sv
// Shared types and constants for the sequenced clock-wakeup drain driver.
package io_clk_wkup_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int unsigned GAP_CYCLES = 1;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_clk_wkup_rr_arb.sv
// Round-robin priority picker: first requester after 'last' (wrapping) wins.
module io_clk_wkup_rr_arb
    import io_clk_wkup_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned LW  = idx_width(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [LW-1:0]  last,
    output logic [NCH-1:0] grant,
    output logic [LW-1:0]  win,
    output logic           valid
);

    always_comb begin
        int unsigned idx;
        logic [LW-1:0] sel;
        idx   = 0;
        sel   = '0;
        grant = '0;
        win   = '0;
        valid = 1'b0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            idx = (32'(last) + i) % NCH;
            sel = LW'(idx);
            if (!valid && req[sel]) begin
                valid      = 1'b1;
                grant[sel] = 1'b1;
                win        = sel;
            end
        end
    end

endmodule

// File: rtl/io_clk_wkup_seq.sv
// Multi-channel round-robin clock-wakeup drain driver with 1-cycle Z gap between channels.
// Optional per-channel completion counters when IO_CLK_WKUP_SEQ_CNT_EN is defined.
module io_clk_wkup_seq
    import io_clk_wkup_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NCH-1:0]   wkup_req,
    input  logic [NCH-1:0]   enb_force,
    input  logic [CNT_W-1:0] hold_cycles,
    output logic [NCH-1:0]   drain_out,
    output logic [NCH-1:0]   drain_oe,
    output logic [NCH-1:0]   wkup_done,
    output logic             busy
`ifdef IO_CLK_WKUP_SEQ_CNT_EN
    , output logic [NCH*4-1:0] wkup_cnt
`endif
);

    localparam int unsigned LW = idx_width(NCH);
    localparam int unsigned GW = 4;

    state_t           state, state_n;
    logic [NCH-1:0]   pend, pend_n;
    logic [NCH-1:0]   oe_n, done_n, take;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [LW-1:0]    last, last_n;
    logic [GW-1:0]    gap_cnt, gap_n;
    logic [NCH-1:0]   eligible, grant;
    logic [LW-1:0]    win;
    logic             valid, start;

    assign eligible = pend & ~enb_force;

    io_clk_wkup_rr_arb #(
        .NCH (NCH),
        .LW  (LW)
    ) u_arb (
        .req   (eligible),
        .last  (last),
        .grant (grant),
        .win   (win),
        .valid (valid)
    );

    // 'last' doubles as the index of the channel currently in DRIVE.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last;
        gap_n   = gap_cnt;
        oe_n    = drain_oe;
        done_n  = '0;
        take    = '0;
        start   = valid && ((state == IDLE) || (state == GAP && gap_cnt == '0));

        case (state)
            IDLE: ;
            DRIVE: begin
                if (enb_force[last]) begin
                    oe_n    = '0;
                    state_n = GAP;
                    gap_n   = GW'(GAP_CYCLES - 1);
                end else if (cnt == '0) begin
                    oe_n         = '0;
                    done_n[last] = 1'b1;
                    state_n      = GAP;
                    gap_n        = GW'(GAP_CYCLES - 1);
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt != '0) begin
                    gap_n = gap_cnt - 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                oe_n    = '0;
            end
        endcase

        if (start) begin
            state_n = DRIVE;
            cnt_n   = hold_cycles;
            oe_n    = grant;
            last_n  = win;
            take    = grant;
        end

        pend_n = ((pend & ~take) | wkup_req) & ~enb_force;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            pend      <= '0;
            cnt       <= '0;
            last      <= LW'(NCH - 1);
            gap_cnt   <= '0;
            drain_oe  <= '0;
            wkup_done <= '0;
        end else begin
            state     <= state_n;
            pend      <= pend_n;
            cnt       <= cnt_n;
            last      <= last_n;
            gap_cnt   <= gap_n;
            drain_oe  <= oe_n;
            wkup_done <= done_n;
        end
    end

    assign busy = (state != IDLE) || (|pend);

    for (genvar g = 0; g < NCH; g++) begin : g_drain
        assign drain_out[g] = drain_oe[g] ? 1'b1 : 1'bz;
    end

`ifdef IO_CLK_WKUP_SEQ_CNT_EN
    for (genvar g = 0; g < NCH; g++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (!rstn) begin
                wkup_cnt[g*4 +: 4] <= '0;
            end else if (wkup_done[g] && wkup_cnt[g*4 +: 4] != 4'hF) begin
                wkup_cnt[g*4 +: 4] <= wkup_cnt[g*4 +: 4] + 4'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_io_clk_wkup_seq.sv
// Scoreboard bench: a time-based service model predicts each drive episode; a monitor checks them.
module tb_io_clk_wkup_seq;

    localparam int NCH   = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rstn;
    logic [NCH-1:0]   wkup_req;
    logic [NCH-1:0]   enb_force;
    logic [CNT_W-1:0] hold_cycles;
    wire  [NCH-1:0]   drain_out;
    logic [NCH-1:0]   drain_oe;
    logic [NCH-1:0]   wkup_done;
    logic             busy;
`ifdef IO_CLK_WKUP_SEQ_CNT_EN
    logic [NCH*4-1:0] wkup_cnt;
`endif

    io_clk_wkup_seq #(
        .NCH   (NCH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .wkup_req    (wkup_req),
        .enb_force   (enb_force),
        .hold_cycles (hold_cycles),
        .drain_out   (drain_out),
        .drain_oe    (drain_oe),
        .wkup_done   (wkup_done),
        .busy        (busy)
`ifdef IO_CLK_WKUP_SEQ_CNT_EN
        , .wkup_cnt  (wkup_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int start;
        int len;
        bit done;
    } ep_t;

    ep_t exp_q[$];
    int  obs_ch[$];
    bit  obs_done[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: a channel serves hold+1 cycles starting at the edge it is picked,
    // unless forced off earlier; a new pick is never made on the edge a drive ends.
    bit m_rst = 1'b1;
    bit m_pend[NCH];
    int m_ch = -1;
    int m_start, m_len;
    int m_last = NCH - 1;
    bit m_busy = 1'b0;
    bit m_ended;
    int m_win;
    int m_wcnt[NCH];

    always @(posedge clk) begin
        cyc++;
        m_rst = !rstn;
        if (!rstn) begin
            foreach (m_pend[c]) m_pend[c] = 1'b0;
            foreach (m_wcnt[c]) m_wcnt[c] = 0;
            m_ch   = -1;
            m_last = NCH - 1;
            m_busy = 1'b0;
        end else begin
            m_ended = 1'b0;
            m_win   = -1;
            if (m_ch >= 0) begin
                if (enb_force[m_ch]) begin
                    exp_q.push_back('{m_ch, m_start, cyc - m_start, 1'b0});
                    m_ch    = -1;
                    m_ended = 1'b1;
                end else if (cyc - m_start == m_len) begin
                    exp_q.push_back('{m_ch, m_start, m_len, 1'b1});
                    if (m_wcnt[m_ch] < 15) m_wcnt[m_ch]++;
                    m_ch    = -1;
                    m_ended = 1'b1;
                end
            end else begin
                for (int k = 1; k <= NCH; k++) begin
                    int c;
                    c = (m_last + k) % NCH;
                    if (m_win < 0 && m_pend[c] && !enb_force[c]) m_win = c;
                end
                if (m_win >= 0) begin
                    m_ch    = m_win;
                    m_start = cyc;
                    m_len   = int'(hold_cycles) + 1;
                    m_last  = m_win;
                end
            end
            m_busy = (m_ch >= 0) || m_ended;
            for (int c = 0; c < NCH; c++) begin
                m_pend[c] = ((m_pend[c] && c != m_win) || wkup_req[c]) && !enb_force[c];
                if (m_pend[c]) m_busy = 1'b1;
            end
        end
    end

    // Monitor: reconstructs drive episodes from drain_oe and pops the model's expectations.
    logic [NCH-1:0] prev_oe = '0;
    int cur_ch = -1;
    int cur_start = 0;

    always @(negedge clk) begin
        if (m_rst) begin
            chk("reset_oe", int'(drain_oe), 0);
            chk("reset_busy", int'(busy), 0);
            chk("reset_done", int'(wkup_done), 0);
            prev_oe = '0;
            cur_ch  = -1;
        end else begin
            chk("onehot_oe", int'($countones(drain_oe) <= 1), 1);
            chk("drain_out_level", int'(drain_out & drain_oe), int'(drain_oe));
            chk("busy", int'(busy), int'(m_busy));
            if (drain_oe != prev_oe && prev_oe != '0) begin
                ep_t e;
                chk("gap_between", int'(drain_oe), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_episode", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ep_channel", cur_ch, e.ch);
                    chk("ep_start", cur_start, e.start);
                    chk("ep_length", cyc - cur_start, e.len);
                    chk("ep_done", int'(wkup_done), e.done ? (1 << e.ch) : 0);
                    obs_ch.push_back(cur_ch);
                    obs_done.push_back(wkup_done != '0);
                end
            end else begin
                chk("no_done", int'(wkup_done), 0);
            end
            if (drain_oe != prev_oe && drain_oe != '0) begin
                for (int b = 0; b < NCH; b++) if (drain_oe[b]) cur_ch = b;
                cur_start = cyc;
            end
            prev_oe = drain_oe;
        end
    end

    task automatic pulse(input logic [NCH-1:0] v);
        wkup_req = v;
        @(negedge clk);
        wkup_req = '0;
    endtask

    task automatic wait_idle();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        chk("idle_within_budget", int'(seen), 1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        int n;
        rstn        = 1'b0;
        wkup_req    = '1;
        enb_force   = '0;
        hold_cycles = 8'd3;
        repeat (3) @(negedge clk);
        rstn     = 1'b1;
        wkup_req = '0;
        repeat (3) @(negedge clk);
        chk("post_reset_busy", int'(busy), 0);

        // Single channel, hold change during DRIVE must not matter
        hold_cycles = 8'd3;
        pulse(4'b0100);
        @(negedge clk);
        hold_cycles = 8'h55;
        wait_idle();
        n = obs_ch.size();
        chk("single_ch", obs_ch[n-1], 2);

        // Round-robin wrap from last=2
        hold_cycles = 8'd2;
        pulse(4'b1011);
        wait_idle();
        n = obs_ch.size();
        chk("rr_first", obs_ch[n-3], 3);
        chk("rr_second", obs_ch[n-2], 0);
        chk("rr_third", obs_ch[n-1], 1);

        // Abort of ch1 with ch3 pending
        hold_cycles = 8'd10;
        pulse(4'b0010);
        wkup_req = 4'b1000;
        @(negedge clk);
        wkup_req = '0;
        repeat (2) @(negedge clk);
        enb_force = 4'b0010;
        @(negedge clk);
        enb_force = '0;
        wait_idle();
        n = obs_ch.size();
        chk("abort_ch", obs_ch[n-2], 1);
        chk("abort_no_done", int'(obs_done[n-2]), 0);
        chk("after_abort_ch", obs_ch[n-1], 3);
        chk("after_abort_done", int'(obs_done[n-1]), 1);

        // Boundary hold values
        hold_cycles = 8'd0;
        pulse(4'b0001);
        wait_idle();
        hold_cycles = 8'hFF;
        pulse(4'b0100);
        wait_idle();

        // Re-request during own DRIVE -> served twice
        hold_cycles = 8'd5;
        pulse(4'b0001);
        repeat (3) @(negedge clk);
        pulse(4'b0001);
        wait_idle();
        n = obs_ch.size();
        chk("twice_a", obs_ch[n-2], 0);
        chk("twice_b", obs_ch[n-1], 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            wkup_req    = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
            enb_force   = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
            hold_cycles = CNT_W'($urandom_range(0, 6));
            @(negedge clk);
        end
        wkup_req  = '0;
        enb_force = '0;
        wait_idle();

`ifdef IO_CLK_WKUP_SEQ_CNT_EN
        hold_cycles = 8'd0;
        for (int i = 0; i < 17; i++) begin
            pulse(4'b0001);
            wait_idle();
        end
        chk("cnt_sat_ch0", int'(wkup_cnt[3:0]), 15);
        for (int c = 0; c < NCH; c++) chk("cnt_model", int'(wkup_cnt[c*4 +: 4]), m_wcnt[c]);
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
